// File: rtl/space_wire_sync_pkg.sv
// Purpose: shared constants and helpers for the multi-channel async event synchroniser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package space_wire_sync_pkg;

    // Edge selection for which level transitions are counted as events.
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Ceiling log2, used to size the glitch-filter counter.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/space_wire_sync_event_ch.sv
// Purpose: one channel: sync chain, optional glitch filter, edge detect, pending-event counter.
// Latency: input change at edge k -> o_event after edge k+SYNC_STAGES+FILTER_LEN+1.
// Backpressure: none; events queue in a saturating counter, drops flag a sticky overflow.
//
// Ports: i_clk/i_reset (async active-high), i_async raw input, i_ack consume strobe,
//        i_clear_ovf overflow clear; o_event/o_count pending state, o_level filtered level,
//        o_overflow sticky drop flag.
module space_wire_sync_event_ch
    import space_wire_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 3,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_async,
    input  logic             i_ack,
    input  logic             i_clear_ovf,
    output logic             o_event,
    output logic [CNT_W-1:0] o_count,
    output logic             o_level,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level_q, level_d;
    logic                   level_prev_q;
    logic                   edge_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q       <= {SYNC_STAGES{RESET_LEVEL}};
            level_q      <= RESET_LEVEL;
            level_prev_q <= RESET_LEVEL;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], i_async};
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            always_comb begin
                level_d = synced;
            end
        end else begin : g_filt
            localparam int FCW = (clog2(FILTER_LEN + 1) < 1) ? 1 : clog2(FILTER_LEN + 1);
            logic [FCW-1:0] flt_q, flt_d;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    flt_q <= '0;
                end else begin
                    flt_q <= flt_d;
                end
            end

            // A change is accepted once the counter has seen it persist for FILTER_LEN
            // cycles; the level flips on the following edge, so a clean change costs
            // exactly FILTER_LEN extra cycles over the unfiltered path.
            always_comb begin
                flt_d   = flt_q;
                level_d = level_q;
                if (synced != level_q) begin
                    if (flt_q == FCW'(FILTER_LEN)) begin
                        level_d = synced;
                        flt_d   = '0;
                    end else begin
                        flt_d = flt_q + FCW'(1);
                    end
                end else begin
                    flt_d = '0;
                end
            end
        end
    endgenerate

    // Edge strobe is combinational from two registered levels, so it is live in the
    // cycle after the level changes and lands in the counter on the next edge.
    always_comb begin
        edge_s = 1'b0;
        if (EDGE_MODE == EDGE_RISE) begin
            edge_s = level_q & ~level_prev_q;
        end else if (EDGE_MODE == EDGE_FALL) begin
            edge_s = ~level_q & level_prev_q;
        end else begin
            edge_s = level_q ^ level_prev_q;
        end
    end

    // Set of overflow is evaluated after the clear so a simultaneous drop wins.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (i_clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (edge_s && !i_ack) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!edge_s && i_ack && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign o_event    = (cnt_q != '0);
    assign o_count    = cnt_q;
    assign o_level    = level_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/space_wire_sync_event.sv
// Purpose: NUM_CH independent async status lines -> counted, acknowledgeable events.
// Latency: input change at edge k -> o_event after edge k+SYNC_STAGES+FILTER_LEN+1.
// Backpressure: none; per-channel counters absorb bursts, saturate and flag overflow.
//
// Ports: i_clk, i_reset (async active-high), i_async_in[NUM_CH], i_ack[NUM_CH],
//        i_clear_ovf; o_event[NUM_CH], o_count[NUM_CH*CNT_W] (ch n at [n*CNT_W +: CNT_W]),
//        o_level[NUM_CH], o_overflow[NUM_CH].
module space_wire_sync_event
    import space_wire_sync_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 3,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_CH-1:0]       i_async_in,
    input  logic [NUM_CH-1:0]       i_ack,
    input  logic                    i_clear_ovf,
    output logic [NUM_CH-1:0]       o_event,
    output logic [NUM_CH*CNT_W-1:0] o_count,
    output logic [NUM_CH-1:0]       o_level,
    output logic [NUM_CH-1:0]       o_overflow
);

    generate
        if (NUM_CH < 1 || SYNC_STAGES < 2 || EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH ||
            CNT_W < 1 || FILTER_LEN < 0) begin : g_bad_params
            $fatal(1, "space_wire_sync_event: illegal parameter combination");
        end
    endgenerate

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        space_wire_sync_event_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .EDGE_MODE   (EDGE_MODE),
            .CNT_W       (CNT_W),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_async     (i_async_in[g]),
            .i_ack       (i_ack[g]),
            .i_clear_ovf (i_clear_ovf),
            .o_event     (o_event[g]),
            .o_count     (o_count[g*CNT_W +: CNT_W]),
            .o_level     (o_level[g]),
            .o_overflow  (o_overflow[g])
        );
    end

endmodule
